// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the
// shared memory. The slave modport is the arbiter's view of it.
interface mem_port_arbiter_if #(
    parameter int LINE_W = 128
);
    // Instruction-side read port
    logic              i_req_valid;
    logic [31:0]       i_req_addr;
    logic              i_req_ready;
    logic              i_resp_valid;
    logic [LINE_W-1:0] i_resp_data;

    // Data-side read/write port
    logic              d_req_valid;
    logic              d_req_write;
    logic [31:0]       d_req_addr;
    logic [LINE_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [LINE_W-1:0] d_resp_data;

    // Shared memory port (asynchronous read)
    logic [31:0]       mem_addr;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_addr, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_addr, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets an instruction-side reader and a data-side
// reader/writer share one fixed-latency memory port. One transaction is in
// flight at a time; ties are broken round-robin; every response arrives
// exactly LATENCY+1 cycles after its acceptance edge.
module mem_port_arbiter #(
    parameter int LATENCY = 4,   // memory access cycles per request, 1..15
    parameter int LINE_W  = 128  // data path / memory line width
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Counter starts at LATENCY-1 so BUSY lasts exactly LATENCY cycles.
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
    // Requests are line aligned: the low nibble of the byte address is dropped.
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_resp_valid_q, i_resp_valid_d;
    logic              d_resp_valid_q, d_resp_valid_d;
    logic              mem_write_q, mem_write_d;

    logic              sel_i;
    logic              sel_d;

    // Grant selection in IDLE: a lone requester wins, a tie goes to the side
    // that did not win last time.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.i_req_valid && bus.d_req_valid) begin
                sel_i = (last_grant_q == OWN_D);
                sel_d = (last_grant_q == OWN_I);
            end else begin
                sel_i = bus.i_req_valid;
                sel_d = bus.d_req_valid;
            end
        end
    end

    // Next-state and datapath computation for the IDLE -> BUSY -> RESP cycle.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (sel_d) begin
                    owner_d = OWN_D;
                    addr_d  = bus.d_req_addr & LINE_MASK;
                    wr_d    = bus.d_req_write;
                    wdata_d = bus.d_req_wdata;
                end else if (sel_i) begin
                    owner_d = OWN_I;
                    addr_d  = bus.i_req_addr & LINE_MASK;
                    wr_d    = 1'b0;
                    wdata_d = '0;
                end
                if (sel_i || sel_d) begin
                    last_grant_d = owner_d;
                    cnt_d        = CNT_LOAD;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Last access cycle: reads land only in the owner's register.
                    if (!wr_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            i_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are derived from where the FSM is heading.
        i_resp_valid_d = (state_d == RESP) && (owner_d == OWN_I);
        d_resp_valid_d = (state_d == RESP) && (owner_d == OWN_D);
        mem_write_d    = (state_d == BUSY) && (cnt_d == 4'd0) && wr_d;
    end

    // FSM and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= OWN_I;
            last_grant_q   <= OWN_D;
            cnt_q          <= 4'd0;
            addr_q         <= 32'd0;
            wr_q           <= 1'b0;
            wdata_q        <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            mem_write_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wr_q           <= wr_d;
            wdata_q        <= wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
            mem_write_q    <= mem_write_d;
        end
    end

    // Reset masks the strobes in the very cycle it is high, so an aborted
    // transaction can neither write memory nor show a response pulse.
    assign bus.i_req_ready  = sel_i & ~reset;
    assign bus.d_req_ready  = sel_d & ~reset;
    assign bus.i_resp_valid = i_resp_valid_q & ~reset;
    assign bus.d_resp_valid = d_resp_valid_q & ~reset;
    assign bus.mem_write    = mem_write_q & ~reset;
    assign bus.i_resp_data  = i_rdata_q;
    assign bus.d_resp_data  = d_rdata_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, memory access cycles per request; legal range 1..15.
REQ-002 Parameter LINE_W, default 128, width in bits of the data path and of one memory line.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 i_req_valid  input  1  instruction-side read request.
REQ-006 i_req_addr  input  32  instruction-side byte address.
REQ-007 i_req_ready  output  1  instruction-side request accepted this cycle when high with i_req_valid.
REQ-008 i_resp_valid  output  1  one-cycle pulse; i_resp_data is valid.
REQ-009 i_resp_data  output  LINE_W  instruction-side read data.
REQ-010 d_req_valid  input  1  data-side request.
REQ-011 d_req_write  input  1  1 = write, 0 = read.
REQ-012 d_req_addr  input  32  data-side byte address.
REQ-013 d_req_wdata  input  LINE_W  write data.
REQ-014 d_req_ready  output  1  data-side request accepted this cycle when high with d_req_valid.
REQ-015 d_resp_valid  output  1  one-cycle pulse; read data valid, or write-completion acknowledge.
REQ-016 d_resp_data  output  LINE_W  data-side read data.
REQ-017 mem_addr  output  32  address to the shared memory.
REQ-018 mem_write  output  1  write strobe to the shared memory.
REQ-019 mem_wdata  output  LINE_W  write data to the shared memory.
REQ-020 mem_rdata  input  LINE_W  asynchronous read data from the shared memory at mem_addr.

Function
REQ-021 The block SHALL implement the states IDLE, BUSY and RESP.
REQ-022 IDLE: grant to I when only I is valid, to D when only D is valid; when both are valid, grant to the side opposite last_grant (round-robin).
REQ-023 The ready output of the granted side SHALL be high combinationally in IDLE; all ready outputs SHALL be low in BUSY and RESP.
REQ-024 On acceptance (valid & ready): latch owner, the address with bits [3:0] forced to 0, the write flag (0 for I), and the wdata; set last_grant to owner; load counter with LATENCY-1; go to BUSY.
REQ-025 BUSY: mem_addr SHALL hold the latched address; counter decrements each cycle.
REQ-026 BUSY with counter==0: mem_write SHALL be high for exactly this cycle if the latched write flag is 1; for reads, capture mem_rdata into the owner's resp_data register; go to RESP.
REQ-027 RESP: the owner's resp_valid SHALL be high for exactly one cycle; go to IDLE.
REQ-028 Latency SHALL be fixed: resp_valid is asserted LATENCY+1 cycles after the acceptance edge, regardless of contention.
REQ-029 A new request SHALL NOT be accepted in the RESP cycle; the earliest next acceptance is in the first IDLE cycle after RESP.
REQ-030 A write SHALL leave d_resp_data unchanged; an I read SHALL never modify d_resp_data, and vice versa.
REQ-031 Requesters hold valid, addr and wdata until accepted; a valid dropped before acceptance SHALL be ignored.
REQ-032 mem_write SHALL be 0 in all states except the write cycle defined in REQ-026.
REQ-033 mem_wdata SHALL drive the latched wdata at all times.

Reset
REQ-034 While reset is high at a rising edge: state to IDLE, counter 0, last_grant to D (first tie goes to I), latched address/wdata/flag 0, both resp_data 0, all resp_valid 0; mem_write SHALL be 0 in that cycle.
REQ-035 Reset during BUSY or RESP SHALL abort the transaction, produce no response pulse and suppress any pending write.

Verification
REQ-036 LATENCY=4, only i_req_valid, addr 0x104 -> accepted at edge 0, mem_addr=0x100 during BUSY, i_resp_valid high in cycle 5 with i_resp_data = mem_rdata sampled in cycle 4.
REQ-037 I and D valid together from reset, held -> grants I, D, I, D alternately; each response 5 cycles after its acceptance; no ready during BUSY/RESP.
REQ-038 D write addr 0x20, wdata 0xA5...A5 -> mem_write high exactly one cycle (4th BUSY cycle), d_resp_valid pulse next cycle, d_resp_data unchanged.
REQ-039 Reset asserted in the 2nd BUSY cycle of a D write -> mem_write never asserted, no d_resp_valid, state IDLE; next tie grants I.
REQ-040 LATENCY=1, back-to-back I reads -> one BUSY cycle each, response 2 cycles after acceptance, acceptances 3 cycles apart.
